// File: rtl/tlb_pkg.sv
// Shared TLB maintenance definitions: op/state encodings, INVTLB ops and the INVTLB entry-match rule.
// Pure declarations, no timing or flow control.
package tlb_pkg;

  localparam int TLBNUM_DEF = 16;
  localparam int IDX_W_DEF  = 4;

  typedef enum logic [1:0] {
    TLB_OP_WR   = 2'b00,
    TLB_OP_FILL = 2'b01,
    TLB_OP_INV  = 2'b10,
    TLB_OP_RD   = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_ERR   = 3'd4
  } tlb_state_e;

  localparam logic [4:0] INV_ALL0         = 5'd0;
  localparam logic [4:0] INV_ALL1         = 5'd1;
  localparam logic [4:0] INV_G            = 5'd2;
  localparam logic [4:0] INV_NG           = 5'd3;
  localparam logic [4:0] INV_NG_ASID      = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA   = 5'd5;
  localparam logic [4:0] INV_G_OR_ASID_VA = 5'd6;

  localparam logic [5:0] PS_4M = 6'd21;

  // A 4M page only carries vppn[18:9]; the low bits are offset within the page.
  function automatic logic inv_match(input logic [4:0]  invop,
                                     input logic        e_g,
                                     input logic [9:0]  e_asid,
                                     input logic [18:0] e_vppn,
                                     input logic [5:0]  e_ps,
                                     input logic [9:0]  asid,
                                     input logic [18:0] vppn);
    logic vmatch;
    logic amatch;
    logic m;
    vmatch = (e_ps == PS_4M) ? (e_vppn[18:9] == vppn[18:9]) : (e_vppn == vppn);
    amatch = (e_asid == asid);
    case (invop)
      INV_ALL0, INV_ALL1: m = 1'b1;
      INV_G:              m = e_g;
      INV_NG:             m = !e_g;
      INV_NG_ASID:        m = !e_g && amatch;
      INV_NG_ASID_VA:     m = !e_g && amatch && vmatch;
      INV_G_OR_ASID_VA:   m = (e_g || amatch) && vmatch;
      default:            m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Maintenance command handshake from writeback to the TLB controller.
// valid/ready: a command transfers on the cycle both are high.
interface tlb_maint_ctrl_if
  import tlb_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  tlb_op_e          cmd_op;
  logic [4:0]       cmd_invop;
  logic [9:0]       cmd_asid;
  logic [18:0]      cmd_vppn;
  logic [IDX_W-1:0] csr_index;

  modport master (
    output cmd_valid, cmd_op, cmd_invop, cmd_asid, cmd_vppn, csr_index,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_invop, cmd_asid, cmd_vppn, csr_index,
    output cmd_ready
  );
endinterface

// File: rtl/tlb_fill_lfsr.sv
// Free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1) supplying the TLBFILL victim index.
// Advances every clock; no handshake, the consumer samples it when needed.
module tlb_fill_lfsr #(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         IDX_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  output logic [IDX_W-1:0] idx
);

  logic [7:0] q;

  // Maximal-length taps: a nonzero seed never reaches the all-zero lockup state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= SEED;
    end else begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

  assign idx = q[IDX_W-1:0];

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: WR/FILL/RD finish one cycle after accept, INVTLB walks all TLBNUM entries one per cycle.
// Accepts only when idle (no back-to-back issue); optional perf counters under TLB_MAINT_PERF_CNT_EN.
module tlb_maint_ctrl
  import tlb_pkg::*;
#(
  parameter int         TLBNUM    = TLBNUM_DEF,
  parameter int         IDX_W     = IDX_W_DEF,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             resetn,
  tlb_maint_ctrl_if.slave  cmd,
  output logic             busy,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_windex,
  output logic [IDX_W-1:0] tlb_rindex,
  input  logic             r_e,
  input  logic             r_g,
  input  logic [9:0]       r_asid,
  input  logic [18:0]      r_vppn,
  input  logic [5:0]       r_ps,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_index,
  output logic             rd_done,
  output logic             rd_hit,
  output logic             inv_err,
  output logic             done
`ifdef TLB_MAINT_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cmd_cnt,
  output logic [31:0]      perf_clr_cnt
`endif
);

  tlb_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] scan_cnt;
  logic [IDX_W-1:0] fill_idx;
  logic [4:0]       invop_q;
  logic [9:0]       asid_q;
  logic [18:0]      vppn_q;
  logic             accept;
  logic             scan_last;
  logic             ent_match;

  tlb_fill_lfsr #(
    .SEED  (LFSR_SEED),
    .IDX_W (IDX_W)
  ) u_fill_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .idx    (fill_idx)
  );

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid && (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign scan_last     = (scan_cnt == IDX_W'(TLBNUM - 1));
  assign ent_match     = inv_match(invop_q, r_g, r_asid, r_vppn, r_ps, asid_q, vppn_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            TLB_OP_WR, TLB_OP_FILL: state_nxt = ST_WRITE;
            TLB_OP_RD:              state_nxt = ST_READ;
            default:                state_nxt = (cmd.cmd_invop > INV_G_OR_ASID_VA) ? ST_ERR : ST_SCAN;
          endcase
        end
      end
      ST_SCAN: begin
        if (scan_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FILL takes the LFSR value present on the accepting edge, so the index is fixed for the write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q   <= '0;
      invop_q <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
    end else if (accept) begin
      idx_q   <= (cmd.cmd_op == TLB_OP_FILL) ? fill_idx : cmd.csr_index;
      invop_q <= cmd.cmd_invop;
      asid_q  <= cmd.cmd_asid;
      vppn_q  <= cmd.cmd_vppn;
    end
  end

  // Counter wraps to zero on the last entry, ready for the next walk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt <= '0;
    end else if (state == ST_SCAN) begin
      scan_cnt <= scan_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    tlb_we     = 1'b0;
    tlb_windex = '0;
    tlb_rindex = '0;
    clr_we     = 1'b0;
    clr_index  = '0;
    rd_done    = 1'b0;
    rd_hit     = 1'b0;
    inv_err    = 1'b0;
    done       = 1'b0;
    case (state)
      ST_WRITE: begin
        tlb_we     = 1'b1;
        tlb_windex = idx_q;
        done       = 1'b1;
      end
      ST_READ: begin
        tlb_rindex = idx_q;
        rd_done    = 1'b1;
        rd_hit     = r_e;
        done       = 1'b1;
      end
      ST_SCAN: begin
        tlb_rindex = scan_cnt;
        clr_we     = r_e && ent_match;
        clr_index  = scan_cnt;
        done       = scan_last;
      end
      ST_ERR: begin
        inv_err = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef TLB_MAINT_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_cmd_cnt <= '0;
      perf_clr_cnt <= '0;
    end else begin
      if (accept) begin
        perf_cmd_cnt <= perf_cmd_cnt + 32'd1;
      end
      if (clr_we) begin
        perf_clr_cnt <= perf_clr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl with a small TLB array model behind the read port.
// Inputs driven and outputs sampled on the falling edge.
module tb_tlb_maint_ctrl;
  import tlb_pkg::*;

  logic        clk;
  logic        resetn;
  logic        busy, tlb_we, clr_we, rd_done, rd_hit, inv_err, done;
  logic [3:0]  tlb_windex, tlb_rindex, clr_index;
  logic        r_e, r_g;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
`ifdef TLB_MAINT_PERF_CNT_EN
  logic [31:0] perf_cmd_cnt, perf_clr_cnt;
`endif

  logic [15:0] m_e;
  logic        m_g[16];
  logic [9:0]  m_asid[16];
  logic [18:0] m_vppn[16];
  logic [5:0]  m_ps[16];
  logic        ld;
  logic [15:0] ld_e;

  int vec_cnt = 0;
  int err_cnt = 0;

  tlb_maint_ctrl_if #(.IDX_W(4)) cif ();

  tlb_maint_ctrl #(.TLBNUM(16), .IDX_W(4), .LFSR_SEED(8'hA5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd        (cif),
    .busy       (busy),
    .tlb_we     (tlb_we),
    .tlb_windex (tlb_windex),
    .tlb_rindex (tlb_rindex),
    .r_e        (r_e),
    .r_g        (r_g),
    .r_asid     (r_asid),
    .r_vppn     (r_vppn),
    .r_ps       (r_ps),
    .clr_we     (clr_we),
    .clr_index  (clr_index),
    .rd_done    (rd_done),
    .rd_hit     (rd_hit),
    .inv_err    (inv_err),
    .done       (done)
`ifdef TLB_MAINT_PERF_CNT_EN
    ,
    .perf_cmd_cnt (perf_cmd_cnt),
    .perf_clr_cnt (perf_clr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Valid bits survive reset so a cut-short walk leaves earlier clears visible.
  always @(posedge clk) begin
    if (ld) m_e <= ld_e;
    else if (clr_we) m_e[clr_index] <= 1'b0;
  end

  assign r_e    = m_e[tlb_rindex];
  assign r_g    = m_g[tlb_rindex];
  assign r_asid = m_asid[tlb_rindex];
  assign r_vppn = m_vppn[tlb_rindex];
  assign r_ps   = m_ps[tlb_rindex];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_e(input logic [15:0] e);
    ld_e = e;
    ld   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld   = 1'b0;
  endtask

  task automatic set_ent(input int i, input logic g, input logic [9:0] a,
                         input logic [18:0] v, input logic [5:0] ps);
    m_g[i] = g; m_asid[i] = a; m_vppn[i] = v; m_ps[i] = ps;
  endtask

  // Called on a falling edge; returns on the falling edge of cycle N+1.
  task automatic issue(input tlb_op_e op, input logic [4:0] invop, input logic [9:0] asid,
                       input logic [18:0] vppn, input logic [3:0] idx);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_invop = invop;
    cif.cmd_asid  = asid;
    cif.cmd_vppn  = vppn;
    cif.csr_index = idx;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  logic [4:0]  tbl_op[5]   = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd1};
  logic [15:0] tbl_mask[5] = '{16'h003C, 16'h0003, 16'h0033, 16'h003A, 16'h0000};

  initial begin
    resetn = 1'b0;
    ld = 1'b0; ld_e = '0;
    cif.cmd_valid = 1'b0; cif.cmd_op = TLB_OP_WR; cif.cmd_invop = '0;
    cif.cmd_asid = '0; cif.cmd_vppn = '0; cif.csr_index = '0;
    for (int i = 0; i < 16; i++) set_ent(i, 1'b0, 10'h0, 19'h0, 6'd12);
    @(negedge clk);
    load_e(16'h0000);
    chk("rst_ready", 32'(cif.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({tlb_we, clr_we, rd_done, rd_hit, inv_err, done}), 32'd0);
    chk("rst_idx", 32'({tlb_windex, tlb_rindex, clr_index}), 32'd0);
    resetn = 1'b1;

    // LFSR from A5: 4A, 95, 2A, 54 -> fills see 95 and 54.
    @(negedge clk);
    @(negedge clk);
    issue(TLB_OP_FILL, 5'd0, 10'h0, 19'h0, 4'd0);
    chk("fill1_we", 32'(tlb_we), 32'd1);
    chk("fill1_idx", 32'(tlb_windex), 32'd5);
    chk("fill1_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("fill1_ready", 32'(cif.cmd_ready), 32'd1);
    issue(TLB_OP_FILL, 5'd0, 10'h0, 19'h0, 4'd0);
    chk("fill2_idx", 32'(tlb_windex), 32'd4);
    @(negedge clk);

    issue(TLB_OP_WR, 5'd0, 10'h0, 19'h0, 4'd7);
    chk("wr_we", 32'(tlb_we), 32'd1);
    chk("wr_idx", 32'(tlb_windex), 32'd7);
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_ready_n1", 32'(cif.cmd_ready), 32'd0);
    @(negedge clk);
    chk("wr_ready_n2", 32'(cif.cmd_ready), 32'd1);
    chk("wr_we_off", 32'({tlb_we, done}), 32'd0);

    load_e(16'h0004);
    issue(TLB_OP_RD, 5'd0, 10'h0, 19'h0, 4'd3);
    chk("rd3_done", 32'({rd_done, done}), 32'd3);
    chk("rd3_hit", 32'(rd_hit), 32'd0);
    chk("rd3_ridx", 32'(tlb_rindex), 32'd3);
    @(negedge clk);
    issue(TLB_OP_RD, 5'd0, 10'h0, 19'h0, 4'd2);
    chk("rd2_hit", 32'(rd_hit), 32'd1);
    @(negedge clk);

    set_ent(2, 1'b0, 10'h012, 19'h00400, 6'd12);
    set_ent(5, 1'b1, 10'h000, 19'h00400, 6'd12);
    set_ent(9, 1'b0, 10'h012, 19'h005FF, 6'd21);
    set_ent(11, 1'b0, 10'h012, 19'h00800, 6'd12);
    load_e(16'h0A24);
    issue(TLB_OP_INV, 5'd5, 10'h012, 19'h00400, 4'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("inv5_busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("inv5_ridx%0d", i), 32'(tlb_rindex), 32'(i));
      chk($sformatf("inv5_clr%0d", i), 32'(clr_we), 32'((i == 2) || (i == 9)));
      if (i == 2 || i == 9) chk($sformatf("inv5_cidx%0d", i), 32'(clr_index), 32'(i));
      chk($sformatf("inv5_done%0d", i), 32'(done), 32'(i == 15));
      @(negedge clk);
    end
    chk("inv5_idle", 32'({busy, cif.cmd_ready}), 32'd1);
    chk("inv5_vec", 32'(m_e), 32'h0820);

    for (int i = 0; i < 16; i++) set_ent(i, 1'b0, 10'h0, 19'h0, 6'd12);
    set_ent(0, 1'b1, 10'h012, 19'h00400, 6'd12);
    set_ent(1, 1'b1, 10'h033, 19'h00777, 6'd12);
    set_ent(2, 1'b0, 10'h012, 19'h00400, 6'd12);
    set_ent(3, 1'b0, 10'h012, 19'h00777, 6'd12);
    set_ent(4, 1'b0, 10'h033, 19'h00400, 6'd12);
    set_ent(5, 1'b0, 10'h033, 19'h00777, 6'd12);
    for (int k = 0; k < 5; k++) begin
      load_e(16'h003F);
      issue(TLB_OP_INV, tbl_op[k], 10'h012, 19'h00400, 4'd0);
      wait_done($sformatf("invtbl_done%0d", tbl_op[k]));
      chk($sformatf("invtbl_vec%0d", tbl_op[k]), 32'(m_e), 32'(tbl_mask[k]));
    end

    load_e(16'hFFFF);
    issue(TLB_OP_INV, 5'd7, 10'h012, 19'h00400, 4'd0);
    chk("inv7_err", 32'({inv_err, done}), 32'd3);
    chk("inv7_clr", 32'(clr_we), 32'd0);
    chk("inv7_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("inv7_idle", 32'({inv_err, cif.cmd_ready}), 32'd1);
    chk("inv7_vec", 32'(m_e), 32'hFFFF);

    issue(TLB_OP_INV, 5'd0, 10'h0, 19'h0, 4'd0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("rstscan_ridx", 32'(tlb_rindex), 32'd6);
    resetn = 1'b0;
    #1;
    chk("rstscan_outs", 32'({busy, clr_we, done, tlb_we, rd_done, inv_err}), 32'd0);
    chk("rstscan_ready", 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rstscan_ready2", 32'(cif.cmd_ready), 32'd1);
    chk("rstscan_vec", 32'(m_e), 32'hFFC0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tlb_maint_ctrl.md
Name: tlb_maint_ctrl

Overview:
Sequencer for all TLB maintenance traffic (TLBWR, TLBFILL, TLBRD, INVTLB) issued by the writeback stage.
- Owns the TLB write-port and read-port index and all write enables.
- Generates the pseudo-random TLBFILL index.
- Walks every entry for INVTLB, one entry per cycle.
- Raises busy so the pipeline holds further TLB-touching instructions until the operation completes.

Parameters:
TLBNUM, 16, number of TLB entries (power of 2)
IDX_W, 4, index width = log2(TLBNUM)
LFSR_SEED, 8'hA5, nonzero reset value of the fill LFSR

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  maintenance command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 TLBWR, 01 TLBFILL, 10 INVTLB, 11 TLBRD
cmd_invop  in  5  INVTLB op field
cmd_asid  in  10  INVTLB asid (rj)
cmd_vppn  in  19  INVTLB va[31:13] (rk)
csr_index  in  IDX_W  TLBIDX.index from CSR file
busy  out  1  operation in flight
tlb_we  out  1  TLB write-port enable (fields supplied by CSRs)
tlb_windex  out  IDX_W  write index
tlb_rindex  out  IDX_W  read index
r_e, r_g  in  1 each  read-port entry valid, global
r_asid  in  10  read-port asid
r_vppn  in  19  read-port vppn
r_ps  in  6  read-port page size
clr_we  out  1  clear E bit of entry clr_index
clr_index  out  IDX_W  entry to clear
rd_done  out  1  pulse: read-port data valid for CSR capture; rd_hit = r_e
rd_hit  out  1  valid with rd_done
inv_err  out  1  pulse: illegal invop
done  out  1  pulse: command finished

Behaviour:
- Reset (async, resetn=0): state=IDLE, scan counter=0, LFSR=LFSR_SEED; every output 0 except cmd_ready=1. Reset mid-scan abandons the scan; entries already cleared stay cleared.
- Accept: cmd_ready = (state==IDLE); a command is taken when cmd_valid && cmd_ready in cycle N. op, invop, asid, vppn and csr_index are latched.
- busy = (state!=IDLE).
- States: IDLE, WRITE, READ, SCAN.
  - WRITE (cycle N+1): tlb_we=1, done=1, then IDLE.
    - tlb_windex = latched csr_index for TLBWR.
    - tlb_windex = LFSR[IDX_W-1:0] sampled at acceptance for TLBFILL.
  - READ (cycle N+1): tlb_rindex = latched index; rd_done=1, rd_hit=r_e, done=1, then IDLE.
  - INVTLB with invop>6: inv_err=1 and done=1 at N+1; no entry cleared.
  - INVTLB otherwise, SCAN: tlb_rindex = counter at cycles N+1..N+TLBNUM. clr_we=1 with clr_index=counter when the entry has r_e=1 and the invop match holds. done=1 with the last index (counter==TLBNUM-1); counter wraps to 0; then IDLE.
- INVTLB match rules (vmatch = r_vppn==vppn, compare only [18:9] when r_ps==21):
  - invop 0, 1: all entries
  - invop 2: r_g=1
  - invop 3: r_g=0
  - invop 4: r_g=0 && r_asid==asid
  - invop 5: r_g=0 && r_asid==asid && vmatch
  - invop 6: (r_g=1 || r_asid==asid) && vmatch
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, advances every clock regardless of state. It never reaches zero.
- Outputs tlb_we, clr_we, rd_done, inv_err and done are decoded from state only; they do not depend combinationally on cmd_valid.
- A new command is accepted no earlier than the cycle after done. There is no back-to-back issue.

Optional Feature:
Macro TLB_MAINT_PERF_CNT_EN.
- Defined: adds outputs perf_cmd_cnt[31:0] (increments on each accepted command) and perf_clr_cnt[31:0] (increments on each clr_we). Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package tlb_pkg holds:
  - op encodings TLB_OP_WR/FILL/INV/RD
  - state encodings
  - INVTLB op constants 0..6
  - PS_4M=21
  - TLBNUM/IDX_W defaults
- One natural sub-module, tlb_fill_lfsr: the 8-bit LFSR with seed parameter and index output.

Test Plan:
- TLBWR with csr_index=4'd7, accepted at cycle N → tlb_we=1, tlb_windex=7, done=1 at N+1; cmd_ready=1 at N+2.
- TLBFILL issued twice, first accepted 3 cycles after reset → both tlb_windex values equal the low 4 bits of the LFSR at each acceptance, checked against a model seeded 8'hA5.
- TLBRD with csr_index=3, entry 3 invalid → rd_done=1, rd_hit=0 at N+1; tlb_rindex=3.
- INVTLB op 5, asid=10'h12, vppn=19'h00400, with entries 2 (g=0, asid 12, match), 5 (g=1, match) and 9 (g=0, asid 12, ps=21, vppn[18:9] match) → clr_we only for indices 2 and 9; done at N+16; busy high N+1..N+16.
- INVTLB op 7 → inv_err=1, done=1 at N+1, no clr_we.
- resetn pulled low at scan index 6 of INVTLB op 0 → outputs 0 immediately; after release, cmd_ready=1 and entries 0..5 cleared, 6..15 untouched.
